// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags, sticky error flags and flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads are registered (1-cycle latency).
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int WORDS    = 64,
  parameter int AF_LEVEL = WORDS - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       winc,
  input  logic [WIDTH-1:0]           wdata,
  output logic                       wfull,
  input  logic                       rinc,
  output logic [WIDTH-1:0]           rdata,
  output logic                       rvalid,
  output logic                       rempty,
  output logic [$clog2(WORDS):0]     count,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int N = $clog2(WORDS);
  localparam logic [N:0] C_WORDS = (N+1)'(WORDS);
  localparam logic [N:0] C_AF    = (N+1)'(AF_LEVEL);
  localparam logic [N:0] C_AE    = (N+1)'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [WORDS];
  logic [N:0]       r_wptr;
  logic [N:0]       r_rptr;
  logic [N:0]       r_count;
  logic             r_ovf;
  logic             r_unf;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Flags decode only the registered count, so acceptance sees pre-edge state.
  assign w_full  = (r_count == C_WORDS);
  assign w_empty = (r_count == '0);
  assign w_push  = winc & ~w_full  & ~flush;
  assign w_pop   = rinc & ~w_empty & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (winc & w_full)  r_ovf <= 1'b1;
      if (rinc & w_empty) r_unf <= 1'b1;
    end
  end

  // Storage is never reset or flushed; only pointers define valid contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[N-1:0]] <= wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata  = r_mem[r_rptr[N-1:0]];
  assign rvalid = ~w_empty;
`else
  logic [WIDTH-1:0] r_rdata;
  logic             r_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else if (flush) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_pop;
      if (w_pop) r_rdata <= r_mem[r_rptr[N-1:0]];
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
`endif

  assign wfull        = w_full;
  assign rempty       = w_empty;
  assign count        = r_count;
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param in its default (registered-read) build, WORDS=64.
module tb_sync_fifo_param;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       winc;
  logic [7:0] wdata;
  logic       wfull;
  logic       rinc;
  logic [7:0] rdata;
  logic       rvalid;
  logic       rempty;
  logic [6:0] count;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  sync_fifo_param #(.WIDTH(8), .WORDS(64), .AF_LEVEL(60), .AE_LEVEL(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .winc(winc), .wdata(wdata),
    .wfull(wfull), .rinc(rinc), .rdata(rdata), .rvalid(rvalid), .rempty(rempty),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wfull"},  32'(wfull), 32'd0);
    chk({tag, "_rempty"}, 32'(rempty), 32'd1);
    chk({tag, "_count"},  32'(count), 32'd0);
    chk({tag, "_af"},     32'(almost_full), 32'd0);
    chk({tag, "_ae"},     32'(almost_empty), 32'd1);
    chk({tag, "_ovf"},    32'(overflow), 32'd0);
    chk({tag, "_unf"},    32'(underflow), 32'd0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    chk({tag, "_rdata"},  32'(rdata), 32'd0);
  endtask

  initial begin
    logic [7:0] wv;
    logic [7:0] rv;
    rst_n = 1'b0; flush = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = 8'h00;
    #2;
    chk_reset_outputs("reset");
    #10 rst_n = 1'b1;

    // Fill 0x00..0x3F
    for (int i = 0; i < 64; i++) begin
      winc = 1'b1; wdata = 8'(i);
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_af", 32'(almost_full), 32'(i + 1 >= 60));
      chk("fill_full", 32'(wfull), 32'(i + 1 == 64));
    end

    // Full boundary: push rejected, pop accepted
    winc = 1'b1; rinc = 1'b1; wdata = 8'hEE;
    tick();
    chk("full_both_count", 32'(count), 32'd63);
    chk("full_both_ovf", 32'(overflow), 32'd1);
    chk("full_both_rvalid", 32'(rvalid), 32'd1);
    chk("full_both_rdata", 32'(rdata), 32'h00);
    winc = 1'b0;

    // Drain remaining 63; 0xEE must never appear
    for (int i = 1; i < 64; i++) begin
      rinc = 1'b1;
      tick();
      chk("drain_rdata", 32'(rdata), 32'(i));
      chk("drain_rvalid", 32'(rvalid), 32'd1);
      chk("drain_count", 32'(count), 32'(63 - i));
      chk("drain_ae", 32'(almost_empty), 32'(63 - i <= 4));
    end
    rinc = 1'b0;
    tick();
    chk("idle_rvalid", 32'(rvalid), 32'd0);
    chk("idle_rempty", 32'(rempty), 32'd1);
    chk("idle_rdata_hold", 32'(rdata), 32'h3F);
    chk("idle_unf", 32'(underflow), 32'd0);

    // Empty boundary: push accepted, pop rejected
    winc = 1'b1; rinc = 1'b1; wdata = 8'h55;
    tick();
    chk("empty_both_count", 32'(count), 32'd1);
    chk("empty_both_unf", 32'(underflow), 32'd1);
    chk("empty_both_rvalid", 32'(rvalid), 32'd0);
    chk("empty_both_rempty", 32'(rempty), 32'd0);
    winc = 1'b0;
    tick();
    chk("empty_pop_rdata", 32'(rdata), 32'h55);
    chk("empty_pop_rvalid", 32'(rvalid), 32'd1);
    chk("empty_pop_count", 32'(count), 32'd0);
    rinc = 1'b0;

    // Wrap-around: occupancy 5, 200 cycles simultaneous push/pop
    wv = 8'h80; rv = 8'h80;
    for (int i = 0; i < 5; i++) begin
      winc = 1'b1; wdata = wv; wv++;
      tick();
    end
    chk("wrap_pre_count", 32'(count), 32'd5);
    for (int i = 0; i < 200; i++) begin
      winc = 1'b1; rinc = 1'b1; wdata = wv; wv++;
      tick();
      chk("wrap_count", 32'(count), 32'd5);
      chk("wrap_rvalid", 32'(rvalid), 32'd1);
      chk("wrap_rdata", 32'(rdata), 32'(rv));
      rv++;
    end
    winc = 1'b0; rinc = 1'b0;

    // Reach full, overflow, then pop down to 10
    for (int i = 0; i < 59; i++) begin
      winc = 1'b1; wdata = 8'h11;
      tick();
    end
    chk("refill_full", 32'(wfull), 32'd1);
    tick();
    chk("refill_ovf", 32'(overflow), 32'd1);
    chk("refill_ovf_count", 32'(count), 32'd64);
    winc = 1'b0;
    for (int i = 0; i < 54; i++) begin
      rinc = 1'b1;
      tick();
    end
    rinc = 1'b0;
    chk("preflush_count", 32'(count), 32'd10);

    // Flush together with winc
    flush = 1'b1; winc = 1'b1; wdata = 8'h99;
    tick();
    flush = 1'b0; winc = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_rempty", 32'(rempty), 32'd1);
    chk("flush_ovf", 32'(overflow), 32'd0);
    chk("flush_unf", 32'(underflow), 32'd0);
    chk("flush_rvalid", 32'(rvalid), 32'd0);
    chk("flush_rdata", 32'(rdata), 32'd0);
    winc = 1'b1; wdata = 8'h3C;
    tick();
    winc = 1'b0; rinc = 1'b1;
    tick();
    rinc = 1'b0;
    chk("postflush_rdata", 32'(rdata), 32'h3C);
    chk("postflush_rvalid", 32'(rvalid), 32'd1);
    chk("postflush_count", 32'(count), 32'd0);

    // Asynchronous reset mid-operation at count 30
    for (int i = 0; i < 30; i++) begin
      winc = 1'b1; wdata = 8'(i + 7);
      tick();
    end
    winc = 1'b1; rinc = 1'b1;
    tick();
    chk("prereset_count", 32'(count), 32'd30);
    chk("prereset_rvalid", 32'(rvalid), 32'd1);
    winc = 1'b0; rinc = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    #2 rst_n = 1'b1;
    tick();
    chk_reset_outputs("postreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO for intra-domain buffering between pipeline stages, e.g. between an input handshake and a compute engine. Storage is a register array of configurable width and depth. Beyond basic full/empty it provides:
- an occupancy count;
- programmable almost-full and almost-empty thresholds;
- sticky overflow/underflow error flags;
- a synchronous flush.

Read latency is selectable at compile time between registered and first-word-fall-through.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- WORDS, 64, depth in words; power of two, ≥4
- AF_LEVEL, WORDS-4, almost_full asserts when count ≥ AF_LEVEL
- AE_LEVEL, 4, almost_empty asserts when count ≤ AE_LEVEL
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of contents and error flags
- winc  input  1  push request
- wdata  input  WIDTH  push data
- wfull  output  1  count == WORDS
- rinc  input  1  pop request
- rdata  output  WIDTH  read data
- rvalid  output  1  rdata holds a newly popped word
- rempty  output  1  count == 0
- count  output  $clog2(WORDS)+1  current occupancy, 0..WORDS
- almost_full  output  1  count ≥ AF_LEVEL
- almost_empty  output  1  count ≤ AE_LEVEL
- overflow  output  1  sticky: push attempted while full
- underflow  output  1  sticky: pop attempted while empty

## Operation
Pointers:
- wptr and rptr are binary, N+1 bits (N = $clog2(WORDS)).
- Array index is ptr[N-1:0]; both pointers wrap modulo 2·WORDS.
- count is a dedicated register, not a pointer difference.

Push and pop acceptance:
- A push is accepted when winc & !wfull & !flush. It writes wdata to mem[wptr] and increments wptr.
- A pop is accepted when rinc & !rempty & !flush. It increments rptr.
- Acceptance is judged on pre-edge state only.
- A push while full is rejected even if a pop is accepted in the same cycle.
- A pop while empty is rejected even if a push is accepted in the same cycle.

count update:
- +1 on push only, −1 on pop only.
- Unchanged on simultaneous push and pop, or when neither is accepted.

Flag decode:
- wfull, rempty, almost_full and almost_empty are combinational decodes of the registered count.
- No read-through-write or bypass path exists.

Error flags:
- overflow sets on winc & wfull.
- underflow sets on rinc & rempty.
- Both hold until flush or reset.
- A rejected request never modifies memory, pointers or count.

Flush:
- On the next edge, clears wptr, rptr, count, overflow, underflow, rvalid and registered rdata.
- winc and rinc are ignored in the flush cycle.
- Memory contents are not cleared.

## Timing
Reset (async assert; outputs valid immediately):
- wfull=0, rempty=1, count=0, almost_full=0, almost_empty=1, overflow=0, underflow=0, rvalid=0, rdata=0.
- Pointers are 0.

Default mode (macro undefined):
- On an accepted pop at edge k, rdata is loaded from mem[rptr] at edge k.
- rvalid=1 for exactly the cycle after edge k. Latency is 1 cycle.
- rdata holds its value until the next accepted pop or flush.

Flag timing:
- Push at edge k into an empty FIFO: rempty drops after edge k.
- With default latency, a pop can be accepted at edge k+1 and data appears after edge k+1.

Back-to-back operation:
- Full-throughput push and pop every cycle is sustained with no bubbles.
- This holds at any occupancy other than the empty/full boundaries.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word-fall-through.
  - rdata = mem[rptr] combinationally whenever !rempty; rinc acknowledges and pops that head word.
  - rvalid = !rempty.
  - Reset and flush rdata value is don't-care while rempty=1.
- Undefined: registered read as described under Timing.
- Flags, count, error and flush behaviour are identical in both modes.

## Test plan
- Fill/drain, WORDS=64:
  - Push 0x00..0x3F on consecutive cycles → count reaches 64, wfull=1 after the 64th edge, almost_full first high at count 60.
  - Pop 64 → rdata sequence 0x00..0x3F (rvalid one cycle after each pop), rempty=1 at the end, almost_empty high from count 4.
- Boundaries:
  - At full, winc=rinc=1 → push rejected, pop accepted, count=63, overflow=1, no stored word altered.
  - At empty, winc=rinc=1 → push accepted, pop rejected, count=1, underflow=1.
- Wrap-around: 200 cycles of simultaneous push/pop at occupancy 5 with an incrementing pattern → count stays 5, output order exact across pointer wrap.
- Flush mid-stream: count=10 with overflow set, assert flush together with winc → count=0, rempty=1, overflow=0, rvalid=0. Next push/pop round-trip returns the new data.
- Reset mid-operation: drop rst_n asynchronously mid-cycle at count=30 → every output takes its reset value before the next edge.
- With SYNC_FIFO_FWFT_EN:
  - Push 0xA5 into empty → rdata=0xA5 and rvalid=1 in the cycle after the push edge, with no rinc.
  - rinc → rempty=1, rvalid=0 after the edge.
